camera_sram_writer: RTL

Avalon-MM write master that packs an 8-bit camera pixel byte stream into 32-bit little-endian words and writes them into the dual-port on-chip SRAM through its second slave port. It sits between the GPIO camera capture logic and the SRAM, so the HPS can read finished frames through the first port. It is the initiator counterpart to that memory.

---
 rtl/cam_wr_pkg.sv | 27 ++
 rtl/cam_byte_packer.sv | 58 +++++
 rtl/camera_sram_writer.sv | 100 ++++++++++
 3 files changed

// File: rtl/cam_wr_pkg.sv
// Shared types for the camera-to-SRAM write master.
// Optional feature macro: CAM_WR_PARTIAL_BE_EN (partial byteenable on last word).
package cam_wr_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    DONE
  } state_t;

  // cnt counts bytes modulo 4; full marks a completed word
  typedef struct packed {
    logic       full;
    logic [1:0] cnt;
  } byte_cnt_t;

  function automatic logic [3:0] be_mask(input byte_cnt_t n);
    logic [4:0] m;
    m = (5'd1 << n.cnt) - 5'd1;
    if (n.full) m = 5'h0F;
    return m[3:0];
  endfunction

endpackage

// File: rtl/cam_byte_packer.sv
// Assembles camera bytes little-endian into a 32-bit word with byteenable.
// CAM_WR_PARTIAL_BE_EN selects partial lanes for a short final word.
module cam_byte_packer
  import cam_wr_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clr,
  input  logic        i_push,
  input  logic [7:0]  i_data,
  input  logic        i_eop,
  output logic        o_last,
  output logic        o_eop,
  output logic [31:0] o_word,
  output logic [3:0]  o_be
);

  byte_cnt_t   r_cnt;
  byte_cnt_t   w_cnt_nx;
  logic [31:0] r_word;
  logic [3:0]  r_be;
  logic        r_eop;

  always_comb begin
    w_cnt_nx.cnt  = r_cnt.cnt + 2'd1;
    w_cnt_nx.full = (r_cnt.cnt == 2'(BYTES_PER_WORD - 1));
  end

  assign o_last = i_eop | w_cnt_nx.full;
  assign o_eop  = r_eop;
  assign o_word = r_word;
  assign o_be   = r_be;

  // clearing the word also zero-pads unused lanes of a short last word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_word <= '0;
      r_be   <= '0;
      r_eop  <= 1'b0;
    end else if (i_clr) begin
      r_cnt  <= '0;
      r_word <= '0;
      r_be   <= '0;
      r_eop  <= 1'b0;
    end else if (i_push) begin
      r_cnt <= w_cnt_nx;
      r_eop <= i_eop;
      r_word[{r_cnt.cnt, 3'b000} +: 8] <= i_data;
`ifdef CAM_WR_PARTIAL_BE_EN
      r_be <= be_mask(w_cnt_nx);
`else
      r_be <= 4'hF;
`endif
    end
  end

endmodule

// File: rtl/camera_sram_writer.sv
// Avalon-MM write master packing camera bytes into SRAM words.
// Partial-word byteenable behaviour is set by CAM_WR_PARTIAL_BE_EN.
module camera_sram_writer
  import cam_wr_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        pix_data,
  input  logic              pix_valid,
  input  logic              pix_eop,
  output logic              pix_ready,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic              avm_waitrequest,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words_written
);

  state_t            r_state;
  state_t            w_state_nx;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_words;
  logic              r_pix_ready;
  logic              r_write;
  logic              r_busy;
  logic              r_done;
  logic              w_start;
  logic              w_push;
  logic              w_accept;
  logic              w_last;
  logic              w_eop;

  assign w_start  = start & (r_state == IDLE);
  assign w_push   = pix_valid & r_pix_ready;
  assign w_accept = r_write & ~avm_waitrequest;

  cam_byte_packer u_packer (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_start | w_accept),
    .i_push (w_push),
    .i_data (pix_data),
    .i_eop  (pix_eop),
    .o_last (w_last),
    .o_eop  (w_eop),
    .o_word (avm_writedata),
    .o_be   (avm_byteenable)
  );

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_nx = COLLECT;
      COLLECT: if (w_push && w_last) w_state_nx = WRITE;
      WRITE:   if (w_accept) w_state_nx = w_eop ? DONE : COLLECT;
      DONE:    w_state_nx = IDLE;
    endcase
  end

  // status outputs are registered from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_pix_ready <= 1'b0;
      r_write     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_addr      <= '0;
      r_words     <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_pix_ready <= (w_state_nx == COLLECT);
      r_write     <= (w_state_nx == WRITE);
      r_busy      <= (w_state_nx != IDLE);
      r_done      <= (w_state_nx == DONE);
      if (w_start) begin
        r_addr  <= base_addr;
        r_words <= '0;
      end else if (w_accept) begin
        r_addr <= r_addr + ADDR_W'(1);
        if (~&r_words) r_words <= r_words + (ADDR_W + 1)'(1);
      end
    end
  end

  assign pix_ready     = r_pix_ready;
  assign avm_write     = r_write;
  assign avm_address   = r_addr;
  assign busy          = r_busy;
  assign done          = r_done;
  assign words_written = r_words;

endmodule
